// File: rtl/binary_to_bcd_module.sv
// binary_to_bcd_module: FIFO-to-FIFO 16-bit binary to 4-digit packed BCD converter.
// Iterative double-dabble engine with sign/overflow flags and optional saturation.
module binary_to_bcd_module #(
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] entry_1,
  input  logic        empty,
  output logic        rd,
  output logic [15:0] output_1,
  output logic        sign_out,
  output logic        overflow,
  input  logic        full,
  output logic        wr
);
  typedef enum logic [1:0] {IDLE, PREP, SHIFT, WRITE} state_t;
  state_t      state_q, state_d;
  logic [15:0] data_q, data_d, shift_q, shift_d, out_q, out_d;
  logic [19:0] bcd_q, bcd_d, adj, bcd_n;
  logic [15:0] shift_n, mag;
  logic [3:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d, sign_q, sign_d, ovf_q, ovf_d, ovf_n;
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 5; i++)
      adj[4*i+:4] = (bcd_q[4*i+:4] >= 4'd5) ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
  end
  assign {bcd_n, shift_n} = {adj[18:0], shift_q, 1'b0};
  assign ovf_n = bcd_n[19:16] != 4'd0;
  assign mag   = (SIGNED && data_q[15]) ? ~data_q + 16'd1 : data_q;
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    out_d   = out_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: if (!empty) begin
        data_d  = entry_1;
        state_d = PREP;
      end
      PREP: begin
        shift_d = mag;
        neg_d   = SIGNED && data_q[15];
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift_d = shift_n;
        bcd_d   = bcd_n;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          // final shift lands here, so results are taken from the shifted value
          state_d = WRITE;
          ovf_d   = ovf_n;
          sign_d  = neg_q;
          out_d   = (ovf_n && SATURATE) ? 16'h9999 : bcd_n[15:0];
        end
      end
      WRITE: if (!full) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      out_q   <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      out_q   <= out_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
    end
  assign rd       = (state_q == IDLE) && !empty;
  assign wr       = (state_q == WRITE) && !full;
  assign output_1 = out_q;
  assign sign_out = sign_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_binary_to_bcd_module.sv
// tb_binary_to_bcd_module: directed bench over three parameterisations driven in lockstep.
module tb_binary_to_bcd_module;
  logic clk = 1'b0, reset, empty, full;
  logic [15:0] entry;
  logic rd_a, wr_a, sign_a, ovf_a, rd_b, wr_b, sign_b, ovf_b, rd_c, wr_c, sign_c, ovf_c;
  logic [15:0] out_a, out_b, out_c;
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;
  binary_to_bcd_module #(.SIGNED(1'b1), .SATURATE(1'b1)) dut_a (.clk(clk), .reset(reset),
    .entry_1(entry), .empty(empty), .rd(rd_a), .output_1(out_a), .sign_out(sign_a),
    .overflow(ovf_a), .full(full), .wr(wr_a));
  binary_to_bcd_module #(.SIGNED(1'b1), .SATURATE(1'b0)) dut_b (.clk(clk), .reset(reset),
    .entry_1(entry), .empty(empty), .rd(rd_b), .output_1(out_b), .sign_out(sign_b),
    .overflow(ovf_b), .full(full), .wr(wr_b));
  binary_to_bcd_module #(.SIGNED(1'b0), .SATURATE(1'b0)) dut_c (.clk(clk), .reset(reset),
    .entry_1(entry), .empty(empty), .rd(rd_c), .output_1(out_c), .sign_out(sign_c),
    .overflow(ovf_c), .full(full), .wr(wr_c));
  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic test_reset;
    reset = 1'b1; empty = 1'b1; full = 1'b0; entry = '0;
    step; step;
    checks++;
    if ({out_a, sign_a, ovf_a, rd_a, wr_a} !== 20'h0) begin
      errors++; $display("FAIL reset_state out=%h sign=%b ovf=%b rd=%b wr=%b expected all 0", out_a, sign_a, ovf_a, rd_a, wr_a);
    end
    reset = 1'b0;
    step;
    checks++;
    if (rd_a !== 1'b0 || wr_a !== 1'b0) begin
      errors++; $display("FAIL idle_empty rd=%b wr=%b expected 0 0", rd_a, wr_a);
    end
  endtask
  task automatic run_token(input logic [15:0] v, input logic [15:0] ea, input logic sa, input logic oa,
                           input logic [15:0] eb, input logic ob, input logic [15:0] ec, input logic sc,
                           input logic oc, input string nm);
    int n;
    entry = v; empty = 1'b0;
    #1;
    checks++;
    if (rd_a !== 1'b1) begin errors++; $display("FAIL %s_rd rd=%b expected 1", nm, rd_a); end
    step;
    empty = 1'b1;
    checks++;
    if (rd_a !== 1'b0) begin errors++; $display("FAIL %s_rd_pulse rd=%b expected 0", nm, rd_a); end
    n = 1;
    while (wr_a !== 1'b1 && n < 40) begin step; n++; end
    checks++;
    if (n != 18) begin errors++; $display("FAIL %s_latency got %0d expected 18", nm, n); end
    checks++;
    if (out_a !== ea || sign_a !== sa || ovf_a !== oa) begin
      errors++; $display("FAIL %s_sat out=%h sign=%b ovf=%b expected %h %b %b", nm, out_a, sign_a, ovf_a, ea, sa, oa);
    end
    checks++;
    if (out_b !== eb || sign_b !== sa || ovf_b !== ob) begin
      errors++; $display("FAIL %s_wrap out=%h sign=%b ovf=%b expected %h %b %b", nm, out_b, sign_b, ovf_b, eb, sa, ob);
    end
    checks++;
    if (out_c !== ec || sign_c !== sc || ovf_c !== oc) begin
      errors++; $display("FAIL %s_unsigned out=%h sign=%b ovf=%b expected %h %b %b", nm, out_c, sign_c, ovf_c, ec, sc, oc);
    end
    step;
    checks++;
    if (wr_a !== 1'b0) begin errors++; $display("FAIL %s_wr_pulse wr=%b expected 0", nm, wr_a); end
  endtask
  task automatic test_values;
    run_token(16'h04D2, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h1234, 1'b0, 1'b0, "pos1234");
    run_token(16'hFFE7, 16'h0025, 1'b1, 1'b0, 16'h0025, 1'b0, 16'h5511, 1'b0, 1'b1, "neg25");
    run_token(16'h8000, 16'h9999, 1'b1, 1'b1, 16'h2768, 1'b1, 16'h2768, 1'b0, 1'b1, "min8000");
    run_token(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b0, 16'h5535, 1'b0, 1'b1, "ffff");
    run_token(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "zero");
  endtask
  task automatic test_full;
    int n;
    full = 1'b1; entry = 16'h0063; empty = 1'b0;
    #1;
    checks++;
    if (rd_a !== 1'b1) begin errors++; $display("FAIL full_rd rd=%b expected 1", rd_a); end
    step;
    entry = 16'h0007;
    for (int i = 0; i < 17; i++) step;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wr_a !== 1'b0 || rd_a !== 1'b0 || out_a !== 16'h0099) begin
        errors++; $display("FAIL full_hold%0d wr=%b rd=%b out=%h expected 0 0 0099", i, wr_a, rd_a, out_a);
      end
      if (i < 4) step;
    end
    full = 1'b0;
    #1;
    checks++;
    if (wr_a !== 1'b1 || rd_a !== 1'b0) begin errors++; $display("FAIL full_release wr=%b rd=%b expected 1 0", wr_a, rd_a); end
    step;
    checks++;
    if (rd_a !== 1'b1 || wr_a !== 1'b0) begin errors++; $display("FAIL full_next_rd rd=%b wr=%b expected 1 0", rd_a, wr_a); end
    step;
    empty = 1'b1;
    n = 1;
    while (wr_a !== 1'b1 && n < 40) begin step; n++; end
    checks++;
    if (n != 18 || out_a !== 16'h0007) begin errors++; $display("FAIL full_pending n=%0d out=%h expected 18 0007", n, out_a); end
    step;
  endtask
  task automatic test_reset_mid;
    int w;
    entry = 16'h0321; empty = 1'b0;
    #1;
    step;
    empty = 1'b1;
    for (int i = 0; i < 8; i++) step;
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({out_a, sign_a, ovf_a, rd_a, wr_a} !== 20'h0) begin
      errors++; $display("FAIL reset_mid out=%h sign=%b ovf=%b rd=%b wr=%b expected all 0", out_a, sign_a, ovf_a, rd_a, wr_a);
    end
    step;
    reset = 1'b0;
    w = 0;
    for (int i = 0; i < 25; i++) begin
      if (wr_a === 1'b1) w++;
      step;
    end
    checks++;
    if (w != 0) begin errors++; $display("FAIL reset_no_wr got %0d wr cycles expected 0", w); end
    run_token(16'h0009, 16'h0009, 1'b0, 1'b0, 16'h0009, 1'b0, 16'h0009, 1'b0, 1'b0, "after_reset");
  endtask
  task automatic test_back_to_back;
    logic [15:0] vals [3] = '{16'h0000, 16'h270F, 16'h2710};
    logic [15:0] exp_a [3] = '{16'h0000, 16'h9999, 16'h9999};
    logic [15:0] exp_b [3] = '{16'h0000, 16'h9999, 16'h0000};
    logic        exp_o [3] = '{1'b0, 1'b0, 1'b1};
    int n, last;
    entry = vals[0]; empty = 1'b0; last = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n = 0;
      while (rd_a !== 1'b1 && n < 40) begin step; n++; end
      if (k > 0) begin
        checks++;
        if (cyc - last != 19) begin errors++; $display("FAIL b2b_spacing%0d got %0d expected 19", k, cyc - last); end
      end
      last = cyc;
      step;
      if (k < 2) entry = vals[k+1]; else empty = 1'b1;
      n = 1;
      while (wr_a !== 1'b1 && n < 40) begin step; n++; end
      checks++;
      if (n != 18 || out_a !== exp_a[k] || ovf_a !== exp_o[k] || out_b !== exp_b[k] || rd_a !== 1'b0) begin
        errors++; $display("FAIL b2b_out%0d n=%0d out=%h ovf=%b wrap=%h rd=%b expected 18 %h %b %h 0", k, n, out_a, ovf_a, out_b, rd_a, exp_a[k], exp_o[k], exp_b[k]);
      end
      step;
    end
  endtask
  initial begin
    test_reset;
    test_values;
    test_full;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
